mel_weight_sched: RTL

Scheduler that sequences the mel filter-bank coefficient SRAM against the incoming STFT magnitude stream and drives the dual-MAC mel accumulator. For every accepted bin it reads the bin's coefficient entry, which holds two weights and two MAC toggle bits. It then re-times bin, weights and toggle state into one aligned beat. At end of frame it flushes any still-open accumulator and reports the number of mel outputs produced. It sits between the STFT magnitude stage and the mel MAC pair.

---
 rtl/mel_pkg.sv | 33 +++
 rtl/mel_weight_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mel_pkg.sv
// Shared state encoding, defaults and coefficient-entry field layout for the mel weight scheduler.
package mel_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int N_MEL_DEF = 40;
  localparam int N_FFT_DEF = 512;
  localparam int LAST_BIN  = N_FFT_DEF / 2;

  // Coefficient entry: {toggle mask {t1,t2}, weight 2, weight 1}, LSB first.
  localparam int W1_LSB = 0;
  localparam int TGL_W  = 2;

  function automatic int w2_lsb(input int width);
    return width;
  endfunction

  function automatic int tgl_lsb(input int width);
    return 2 * width;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH1,
    S_FLUSH2,
    S_DONE
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mel_weight_sched.sv
// Sequences coefficient-SRAM reads against the STFT bin stream and drives the dual-MAC mel accumulator.
// Accept-to-output latency 2 cycles at 1 beat/cycle; rdy drops from the last bin through flush and done.
module mel_weight_sched
  import mel_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int N_MEL             = N_MEL_DEF,
  parameter int N_FFT             = N_FFT_DEF,
  parameter int NZ_MEL_SRAM_DEPTH = N_FFT_DEF / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 stft_bin_vld,
  output logic                 stft_bin_rdy,
  input  logic [WIDTH-1:0]     stft_bin,
  input  logic [8:0]           stft_bin_idx,
  output logic                 sram_rd_en,
  output logic [8:0]           sram_addr,
  input  logic [2*WIDTH+1:0]   sram_rdata,
  output logic                 fft_bin_vld,
  output logic [WIDTH-1:0]     fft_bin,
  output logic [2*WIDTH-1:0]   mel_fbank_weight,
  output logic [1:0]           mac_bits,
  output logic                 frame_done,
  output logic [7:0]           mel_count,
  output logic                 err_seq,
  output logic                 err_count
);

  localparam int         TGL_LSB  = tgl_lsb(WIDTH);
  localparam int         W2_LSB   = w2_lsb(WIDTH);
  localparam logic [8:0] LAST_IDX = 9'(N_FFT / 2);
  localparam logic [8:0] MAX_ADDR = 9'(NZ_MEL_SRAM_DEPTH - 1);

  state_t           state;
  logic [8:0]       exp_idx;
  logic             last_pend;
  logic             s1_vld;
  logic [WIDTH-1:0] s1_bin;
  logic [1:0]       open_q;
  logic [7:0]       mel_cnt;

  logic             accept;
  logic             seq_ok;
  logic             take;
  logic [TGL_W-1:0] tgl;
  logic [7:0]       flush_cnt;

  // No new beat is taken once the last bin is in flight, until the frame has been closed out.
  assign stft_bin_rdy = ((state == S_IDLE) && enable) || ((state == S_RUN) && !last_pend);
  assign accept       = stft_bin_vld && stft_bin_rdy;
  assign seq_ok       = (state == S_IDLE) ? (stft_bin_idx == 9'd0) : (stft_bin_idx == exp_idx);
  assign take         = accept && seq_ok && (stft_bin_idx <= MAX_ADDR);

  assign sram_rd_en = take;
  assign sram_addr  = take ? stft_bin_idx : 9'd0;

  assign tgl       = sram_rdata[TGL_LSB +: TGL_W];
  assign flush_cnt = open_q[0] ? sat_inc(mel_cnt) : mel_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      exp_idx          <= '0;
      last_pend        <= 1'b0;
      s1_vld           <= 1'b0;
      s1_bin           <= '0;
      fft_bin_vld      <= 1'b0;
      fft_bin          <= '0;
      mel_fbank_weight <= '0;
      mac_bits         <= 2'b01;
      open_q           <= 2'b00;
      mel_cnt          <= '0;
      frame_done       <= 1'b0;
      mel_count        <= '0;
      err_seq          <= 1'b0;
      err_count        <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      s1_vld      <= take;
      fft_bin_vld <= s1_vld;

      if (take) begin
        s1_bin  <= stft_bin;
        exp_idx <= stft_bin_idx + 9'd1;
      end

      // SRAM data is only meaningful in the cycle after a read, which is exactly when s1_vld is set.
      if (s1_vld) begin
        fft_bin          <= s1_bin;
        mel_fbank_weight <= {sram_rdata[W2_LSB +: WIDTH], sram_rdata[W1_LSB +: WIDTH]};
        mac_bits         <= mac_bits ^ tgl;
        open_q           <= ~tgl;
        if (^tgl) mel_cnt <= sat_inc(mel_cnt);
      end

      unique case (state)
        S_IDLE: begin
          if (take) begin
            state   <= S_RUN;
            mel_cnt <= '0;
          end
        end
        S_RUN: begin
          if (last_pend) begin
            last_pend <= 1'b0;
            state     <= S_FLUSH1;
          end else if (accept && !take) begin
            err_seq <= 1'b1;
            state   <= S_IDLE;
          end else if (take && (stft_bin_idx == LAST_IDX)) begin
            last_pend <= 1'b1;
          end
        end
        // Flush edges go out one MAC per cycle so downstream never sees a double edge.
        S_FLUSH1: begin
          if (open_q[1]) begin
            mac_bits[1] <= ~mac_bits[1];
            open_q[1]   <= 1'b0;
            mel_cnt     <= sat_inc(mel_cnt);
          end
          state <= S_FLUSH2;
        end
        S_FLUSH2: begin
          if (open_q[0]) begin
            mac_bits[0] <= ~mac_bits[0];
            open_q[0]   <= 1'b0;
          end
          mel_cnt    <= flush_cnt;
          mel_count  <= flush_cnt;
          err_count  <= err_count | (flush_cnt != 8'(N_MEL));
          frame_done <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          mel_cnt <= '0;
          exp_idx <= '0;
          state   <= enable ? S_RUN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
